// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: RV32I fetch stage with PC, imem request/response, redirect and stall; `define FETCH_PERF_CNT_EN adds perf counters
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_killed,
`endif
  output logic        fetch_fault
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
  logic kill_q, kill_d, iv_q, iv_d, fault_q, fault_d;
  logic hs, mis;
  assign imem_req_valid = state_q == REQ && !kill_q;
  assign imem_req_addr = pc_q;
  assign hs = imem_req_valid && imem_req_ready;
  assign mis = redirect_valid && redirect_pc[1:0] != 2'b00;
  assign instr_valid = iv_q;
  assign instr = instr_q;
  assign instr_pc = instr_pc_q;
  assign fetch_fault = fault_q;
  always_comb begin
    state_d = state_q;
    kill_d = kill_q && !imem_resp_valid;
    instr_d = instr_q;
    instr_pc_d = instr_pc_q;
    iv_d = iv_q;
    fault_d = redirect_valid ? mis : fault_q;
    pc_d = redirect_valid ? redirect_pc : (state_q == HOLD && !stall) ? pc_q + 32'd4 : pc_q;
    case (state_q)
      REQ: begin
        state_d = hs && !redirect_valid ? WAIT : REQ;
        kill_d = kill_d || (hs && redirect_valid);
      end
      WAIT:
        if (redirect_valid) begin
          state_d = REQ;
          kill_d = !imem_resp_valid;
        end else if (imem_resp_valid && !kill_q) begin
          state_d = HOLD;
          instr_d = imem_resp_data;
          instr_pc_d = pc_q;
          iv_d = 1'b1;
        end
      HOLD:
        if (redirect_valid || !stall) begin
          state_d = REQ;
          iv_d = 1'b0;
        end
      FAULT: state_d = redirect_valid && !mis ? REQ : FAULT;
    endcase
    // a misaligned target overrides every state's transition
    if (mis) begin
      state_d = FAULT;
      iv_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      kill_q <= 1'b0;
      instr_q <= '0;
      instr_pc_q <= '0;
      iv_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      kill_q <= kill_d;
      instr_q <= instr_d;
      instr_pc_q <= instr_pc_d;
      iv_q <= iv_d;
      fault_q <= fault_d;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, stall_cyc_q, killed_q;
  logic consumed, stalled, dropped;
  assign consumed = state_q == HOLD && !stall;
  assign stalled = state_q == HOLD && stall && !redirect_valid;
  assign dropped = imem_resp_valid && (kill_q || (state_q == WAIT && redirect_valid));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_cyc_q <= '0;
      killed_q <= '0;
    end else begin
      fetched_q <= fetched_q + {31'b0, consumed};
      stall_cyc_q <= stall_cyc_q + {31'b0, stalled};
      killed_q <= killed_q + {31'b0, dropped};
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_stall_cycles = stall_cyc_q;
  assign perf_killed = killed_q;
`endif
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: directed + random scoreboard bench for rv32i_fetch_unit
module tb_rv32i_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_resp_valid, redirect_valid, stall;
  logic instr_valid, fetch_fault;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, instr, instr_pc;
  always #5 clk = ~clk;
  rv32i_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
  );
  typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
  typedef struct {logic [31:0] addr; int due;} pend_t;
  exp_t exp_q[$];
  pend_t pend_q[$];
  exp_t cur;
  logic [31:0] ref_pc;
  bit fault_m, prev_iv, have_prev, check_interval;
  int checks = 0, fails = 0, cyc = 0, mcyc = 0, last_due = 0, idle = 0, last_pres = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  function automatic logic [31:0] rand_target();
    int r;
    logic [31:0] t;
    r = $urandom_range(0, 9);
    t = $urandom_range(0, 4095);
    if (r < 2) return (t & ~32'h3) | 32'($urandom_range(1, 3));
    if (r == 2) return 32'hFFFF_FFF0 + {28'b0, t[1:0], 2'b00};
    return {t[31:2], 2'b00};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    pend_q.delete();
    last_due = 0;
    repeat (2) @(negedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back('{RESET_PC, mem_word(RESET_PC)});
    ref_pc = RESET_PC; fault_m = 1'b0; idle = 0;
    rst_n = 1'b1;
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
  endtask
  // one cycle: memory model, input drive, reference model update for the coming edge
  task automatic step(input bit rnd, input bit st, input bit rv, input logic [31:0] rt);
    pend_t p;
    int due;
    @(negedge clk); #1;
    cyc++;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data = mem_word(p.addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
    end
    imem_req_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    stall = rnd ? ($urandom_range(0, 2) == 0) : st;
    redirect_valid = rnd ? ($urandom_range(0, 15) == 0) : rv;
    redirect_pc = rnd ? rand_target() : rt;
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, ref_pc);
      due = cyc + (rnd ? int'($urandom_range(1, 3)) : 1);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{imem_req_addr, due});
    end
    if (redirect_valid) begin
      ref_pc = redirect_pc;
      fault_m = redirect_pc[1:0] != 2'b00;
      exp_q.delete();
      if (!fault_m) exp_q.push_back('{redirect_pc, mem_word(redirect_pc)});
    end else if (instr_valid && !stall) begin
      ref_pc = ref_pc + 32'd4;
      exp_q.push_back('{ref_pc, mem_word(ref_pc)});
    end
    if (instr_valid || fault_m || redirect_valid) idle = 0;
    else if (++idle > 40) begin
      checks++; fails++;
      $display("FAIL liveness: %0d cycles without an instruction, limit 40", idle);
      idle = 0;
    end
  endtask
  task automatic run_until_hold(input bit st);
    int n;
    n = 0;
    while (!instr_valid && n < 30) begin
      step(1'b0, st, 1'b0, 32'd0);
      n++;
    end
    if (!instr_valid) begin
      checks++; fails++;
      $display("FAIL hold_timeout: instr_valid low after %0d cycles", n);
    end
  endtask
  always @(negedge clk) begin
    mcyc++;
    if (!rst_n) begin
      prev_iv = 1'b0;
      have_prev = 1'b0;
    end else begin
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, fault_m});
      if (fault_m) begin
        chk("req_in_fault", {31'b0, imem_req_valid}, 32'd0);
        chk("instr_in_fault", {31'b0, instr_valid}, 32'd0);
      end
      if (instr_valid) begin
        if (!(prev_iv && stall && !redirect_valid)) begin
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_instr: instr_pc %h presented, none expected", instr_pc);
          end else cur = exp_q.pop_front();
          if (check_interval && have_prev) chk("pres_interval", 32'(mcyc - last_pres), 32'd3);
          last_pres = mcyc;
          have_prev = 1'b1;
        end
        chk("instr_pc", instr_pc, cur.pc);
        chk("instr", instr, cur.data);
      end
      prev_iv = instr_valid;
    end
  end
  initial begin
    do_reset();
    check_interval = 1'b1;
    repeat (14) step(1'b0, 1'b0, 1'b0, 32'd0);
    check_interval = 1'b0;
    run_until_hold(1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    run_until_hold(1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    run_until_hold(1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h102);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h200);
    run_until_hold(1'b1);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    run_until_hold(1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    run_until_hold(1'b1);
    repeat (2500) step(1'b1, 1'b0, 1'b0, 32'd0);
    do_reset();
    repeat (2500) step(1'b1, 1'b0, 1'b0, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
